// File: rtl/seg_scan_driver_if.sv
// Display-driver bus: the CPU side writes digit data and strobes load, the
// driver side returns the multiplexed pins and the frame-boundary pulse.
//   data       : 4*DIGITS hex nibbles, digit 0 in data[3:0]
//   dp, blank  : per-digit decimal point / forced blank
//   lz_en      : leading-zero suppression enable
//   load       : one-cycle strobe capturing data/dp/blank/lz_en
//   segan_en   : digit enables (one active at a time)
//   segans     : segments {dp,g,f,e,d,c,b,a}
//   frame_done : one-cycle pulse after the scan wraps to digit 0
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                lz_en;
  logic                load;
  logic [DIGITS-1:0]   segan_en;
  logic [7:0]          segans;
  logic                frame_done;

  modport master (
    output data, dp, blank, lz_en, load,
    input  segan_en, segans, frame_done
  );

  modport slave (
    input  data, dp, blank, lz_en, load,
    output segan_en, segans, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with a tear-free double buffer.
// A prescaler produces one tick every CLK_DIV cycles; each tick advances the
// digit index and registers the enable/segment pattern for the new digit.
// New display contents are staged in a pending buffer and only move to the
// active buffer when the scan wraps back to digit 0.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : seg_scan_driver_if.slave (data/dp/blank/lz_en/load in,
//           segan_en/segans/frame_done out)
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 100000,
  parameter int EN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               reset,
  seg_scan_driver_if.slave  bus
);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [DIGITS-1:0] EN_OFF  = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  function automatic logic [7:0] hex_decode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h3F;  4'h1: s = 8'h06;  4'h2: s = 8'h5B;  4'h3: s = 8'h4F;
      4'h4: s = 8'h66;  4'h5: s = 8'h6D;  4'h6: s = 8'h7D;  4'h7: s = 8'h07;
      4'h8: s = 8'h7F;  4'h9: s = 8'h6F;  4'hA: s = 8'h77;  4'hB: s = 8'h7C;
      4'hC: s = 8'h39;  4'hD: s = 8'h5E;  4'hE: s = 8'h79;  default: s = 8'h71;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] s);
    return (SEG_ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic [DIGITS-1:0] en_pol(input logic [DIGITS-1:0] e);
    return (EN_ACTIVE_LOW != 0) ? ~e : e;
  endfunction

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] act_data, pend_data, nx_data;
  logic [DIGITS-1:0]   act_dp, pend_dp, nx_dp;
  logic [DIGITS-1:0]   act_blank, pend_blank, nx_blank;
  logic                act_lz, pend_lz, nx_lz;
  logic                pend_vld;
  logic                frame_done_p1;
  logic [DIGITS-1:0]   en_p1;
  logic [7:0]          seg_p1;

  logic                vld_p0;
  logic                wrap_p0;
  logic [IDX_W-1:0]    idx_nxt_p0;
  logic [DIGITS-1:0]   supp_p0;
  logic                run_zero;
  logic [3:0]          nib_p0;
  logic                off_p0;
  logic [7:0]          seg_raw_p0;
  logic [DIGITS-1:0]   en_raw_p0;

  // ---- stage p0: tick detect, buffer select and digit decode ----
  assign vld_p0     = (cnt == CNT_W'(CLK_DIV - 1));
  assign wrap_p0    = vld_p0 && (idx == IDX_W'(DIGITS - 1));
  assign idx_nxt_p0 = wrap_p0 ? '0 : idx + IDX_W'(1);

  // The decode must see the buffer that becomes active on the wrap tick, so
  // digit 0 of a new frame already shows freshly committed data.
  always_comb begin
    nx_data  = act_data;
    nx_dp    = act_dp;
    nx_blank = act_blank;
    nx_lz    = act_lz;
    if (wrap_p0 && bus.load) begin
      nx_data  = bus.data;
      nx_dp    = bus.dp;
      nx_blank = bus.blank;
      nx_lz    = bus.lz_en;
    end else if (wrap_p0 && pend_vld) begin
      nx_data  = pend_data;
      nx_dp    = pend_dp;
      nx_blank = pend_blank;
      nx_lz    = pend_lz;
    end
  end

  // Scan from the top digit down; a digit is suppressed while every nibble
  // from the top down to it is zero. Digit 0 is never suppressed.
  always_comb begin
    run_zero = 1'b1;
    supp_p0  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero   = run_zero & (nx_data[4*i +: 4] == 4'h0);
      supp_p0[i] = run_zero & nx_lz;
    end
  end

  assign nib_p0     = 4'(nx_data >> {idx_nxt_p0, 2'b00});
  assign off_p0     = nx_blank[idx_nxt_p0] | supp_p0[idx_nxt_p0];
  assign seg_raw_p0 = hex_decode(nib_p0) | {nx_dp[idx_nxt_p0], 7'b0};
  assign en_raw_p0  = DIGITS'(1) << idx_nxt_p0;

  // ---- stage p1: registered pins, buffers and scan state ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt           <= '0;
      idx           <= '0;
      act_data      <= '0;
      act_dp        <= '0;
      act_blank     <= '0;
      act_lz        <= 1'b0;
      pend_data     <= '0;
      pend_dp       <= '0;
      pend_blank    <= '0;
      pend_lz       <= 1'b0;
      pend_vld      <= 1'b0;
      frame_done_p1 <= 1'b0;
      en_p1         <= EN_OFF;
      seg_p1        <= SEG_OFF;
    end else begin
      cnt           <= vld_p0 ? '0 : cnt + CNT_W'(1);
      frame_done_p1 <= wrap_p0;
      if (vld_p0) begin
        idx    <= idx_nxt_p0;
        en_p1  <= off_p0 ? EN_OFF  : en_pol(en_raw_p0);
        seg_p1 <= off_p0 ? SEG_OFF : seg_pol(seg_raw_p0);
      end
      if (wrap_p0) begin
        act_data  <= nx_data;
        act_dp    <= nx_dp;
        act_blank <= nx_blank;
        act_lz    <= nx_lz;
        pend_vld  <= 1'b0;
      end else if (bus.load) begin
        pend_data  <= bus.data;
        pend_dp    <= bus.dp;
        pend_blank <= bus.blank;
        pend_lz    <= bus.lz_en;
        pend_vld   <= 1'b1;
      end
    end
  end

  assign bus.segan_en   = en_p1;
  assign bus.segans     = seg_p1;
  assign bus.frame_done = frame_done_p1;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 4-cycle slots, active-low pins).
// A frame-level reference model tracks cycles since reset, derives slot and
// digit from plain arithmetic and predicts the pins on every clock.
module tb_seg_scan_driver;
  localparam int D     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = D * DIV;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.DIGITS(D)) bus ();

  seg_scan_driver #(
    .DIGITS(D), .CLK_DIV(DIV), .EN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [4*D-1:0] data;
    logic [D-1:0]   dp;
    logic [D-1:0]   blank;
    logic           lz;
  } disp_t;

  logic [7:0] font [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  disp_t      m_act, m_pend;
  logic       m_pvld;
  int         t;
  logic [D-1:0] e_en;
  logic [7:0] e_seg;
  logic       e_fd;
  int         last_k;
  logic       last_tick;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         fd_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What digit k of the active frame should look like on the pins.
  task automatic expect_digit(input int k);
    logic suppressed;
    logic [3:0] nib;
    suppressed = m_act.lz && (k != 0) && ((m_act.data >> (4 * k)) == 0);
    nib = 4'(m_act.data >> (4 * k));
    if (m_act.blank[k] || suppressed) begin
      e_en  = '1;
      e_seg = 8'hFF;
    end else begin
      e_en  = ~(D'(1) << k);
      e_seg = ~(font[nib] | (m_act.dp[k] ? 8'h80 : 8'h00));
    end
  endtask

  task automatic step();
    disp_t in_now;
    logic  rst_now, load_now, tick, wrap;
    int    k;
    in_now   = '{bus.data, bus.dp, bus.blank, bus.lz_en};
    rst_now  = reset;
    load_now = bus.load;
    @(posedge clk);
    tick = 1'b0;
    if (!rst_now) begin
      t = 0; m_act = '0; m_pend = '0; m_pvld = 1'b0;
      e_en = '1; e_seg = 8'hFF; e_fd = 1'b0;
    end else begin
      tick = (((t + 1) % DIV) == 0);
      k    = ((t + 1) / DIV) % D;
      wrap = tick && (k == 0);
      e_fd = wrap;
      if (wrap) begin
        if (load_now) m_act = in_now;
        else if (m_pvld) m_act = m_pend;
        m_pvld = 1'b0;
      end else if (load_now) begin
        m_pend = in_now;
        m_pvld = 1'b1;
      end
      if (tick) begin
        expect_digit(k);
        last_k = k;
      end
      t++;
    end
    last_tick = tick;
    #1;
    if (bus.frame_done === 1'b1) fd_count++;
    check("segan_en", 32'(bus.segan_en), 32'(e_en));
    check("segans", 32'(bus.segans), 32'(e_seg));
    check("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  task automatic run_to_digit(input int k);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (last_tick && last_k == k) return;
    end
    n_checks++;
    n_fail++;
    $error("FAIL run_to_digit: digit %0d never selected within %0d cycles", k, 2 * FRAME);
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] b, input logic lz);
    bus.data = d; bus.dp = p; bus.blank = b; bus.lz_en = lz;
  endtask

  initial begin
    set_inputs(16'h0, 4'h0, 4'h0, 1'b0);
    bus.load  = 1'b0;
    last_k    = 0;
    last_tick = 1'b0;
    fd_count  = 0;

    // Reset and first scan
    reset = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    repeat (3) step();
    check("pre_tick_en", 32'(bus.segan_en), 32'h0000_000F);
    check("pre_tick_seg", 32'(bus.segans), 32'h0000_00FF);
    step();
    check("first_tick_en", 32'(bus.segan_en), 32'h0000_000D);
    check("first_tick_seg", 32'(bus.segans), 32'h0000_00C0);

    // Decode and scan order
    set_inputs(16'h12AF, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1; step(); bus.load = 1'b0;
    repeat (2 * FRAME) step();
    fd_count = 0;
    repeat (2 * FRAME) step();
    check("frame_done_count", 32'(fd_count), 32'd2);
    run_to_digit(3);
    check("digit3_seg_1", 32'(bus.segans), 32'h0000_00F9);
    check("digit3_en", 32'(bus.segan_en), 32'h0000_0007);
    run_to_digit(0);
    check("digit0_seg_F", 32'(bus.segans), 32'h0000_008E);

    // Double buffering: two loads mid-frame, last one wins at the boundary
    run_to_digit(1);
    set_inputs(16'h1111, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1; step(); bus.load = 1'b0;
    step();
    set_inputs(16'h2222, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1; step(); bus.load = 1'b0;
    run_to_digit(0);
    check("dbuf_digit0", 32'(bus.segans), 32'h0000_00A4);
    repeat (2 * FRAME) step();

    // Load exactly on the wrap tick, with a stale pending entry queued
    run_to_digit(1);
    set_inputs(16'h4444, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1; step(); bus.load = 1'b0;
    while (((t + 1) % FRAME) != 0) step();
    set_inputs(16'h3333, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1; step(); bus.load = 1'b0;
    check("boundary_load_seg", 32'(bus.segans), 32'h0000_00B0);
    check("boundary_load_en", 32'(bus.segan_en), 32'h0000_000E);
    run_to_digit(0);
    check("boundary_no_stale", 32'(bus.segans), 32'h0000_00B0);

    // Leading-zero suppression, blanking, decimal point
    set_inputs(16'h0050, 4'b0001, 4'h0, 1'b1);
    bus.load = 1'b1; step(); bus.load = 1'b0;
    repeat (FRAME) step();
    run_to_digit(1);
    check("lz_digit1", 32'(bus.segans), 32'h0000_0092);
    run_to_digit(0);
    check("lz_digit0_dp", 32'(bus.segans), 32'h0000_0040);
    run_to_digit(2);
    check("lz_digit2_en", 32'(bus.segan_en), 32'h0000_000F);
    check("lz_digit2_seg", 32'(bus.segans), 32'h0000_00FF);
    set_inputs(16'h0907, 4'b1010, 4'b0100, 1'b0);
    bus.load = 1'b1; step(); bus.load = 1'b0;
    repeat (2 * FRAME) step();

    // Randomized loads against the model
    for (int i = 0; i < 600; i++) begin
      set_inputs(16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                 1'($urandom));
      if ($urandom_range(0, 2) == 0) bus.data[15:8] = 8'h00;
      bus.load = ($urandom_range(0, 9) == 0);
      step();
    end
    bus.load = 1'b0;

    // Reset in the middle of a frame
    set_inputs(16'h8888, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1; step(); bus.load = 1'b0;
    repeat (2 * FRAME) step();
    run_to_digit(2);
    reset = 1'b0; step(); reset = 1'b1;
    check("midreset_en", 32'(bus.segan_en), 32'h0000_000F);
    check("midreset_seg", 32'(bus.segans), 32'h0000_00FF);
    repeat (4) step();
    check("after_reset_en", 32'(bus.segan_en), 32'h0000_000D);
    check("after_reset_seg", 32'(bus.segans), 32'h0000_00C0);
    repeat (FRAME) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
